// File: rtl/if_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } if_state_t;

    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} words. The head entry is
// presented from registered storage; clear wins over push and pop.
module if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_pop;

    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign level      = count;

    // Entry storage needs no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; a clear empties the FIFO at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch stage: owns the PC, fetches words from the ROM over a
// req/ack handshake, buffers them in if_fifo and hands them to IF/ID.
// Optional feature macro: IF_BYPASS_EN (ROM word forwarded straight to IF/ID
// when the FIFO is empty and IF/ID is ready).
module inst_prefetch
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_req,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic                   rom_ack,
    input  logic [DATA_W-1:0]      rom_rdata,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      flush_pc,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [ADDR_W-1:0]      if_pc,
    output logic [DATA_W-1:0]      if_inst,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int           LW      = $clog2(DEPTH) + 1;
    localparam logic [LW:0]  DEPTH_W = (LW+1)'(DEPTH);

`ifdef IF_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    if_state_t                state_q;
    if_state_t                state_d;
    logic [ADDR_W-1:0]        pc_q;
    logic [ADDR_W-1:0]        pc_d;
    logic [ADDR_W-1:0]        target_q;
    logic [ADDR_W-1:0]        target_d;
    logic                     started_q;
    logic                     accept;
    logic                     bypass;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_clear;
    logic                     head_valid;
    logic [ADDR_W+DATA_W-1:0] head_data;
    logic [LW:0]              level_ext;
    logic                     room_idle;
    logic                     room_after;

    assign level_ext  = {1'b0, fifo_level};
    assign fifo_pop   = head_valid && if_ready && !flush;
    // A pop in the same cycle is counted against the room, so a fresh fetch
    // from IDLE only starts once the consumer has actually drained space.
    assign room_idle  = (level_ext + (LW+1)'(fifo_pop)) < DEPTH_W;
    assign room_after = (level_ext + (LW+1)'(1)) < (DEPTH_W + (LW+1)'(fifo_pop));
    assign bypass     = BYPASS_EN && accept && !head_valid && if_ready;
    assign fifo_push  = accept && !bypass;
    assign rom_addr   = pc_q;
    assign if_valid   = head_valid || bypass;

    if_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  ({pc_q, rom_rdata}),
        .pop        (fifo_pop),
        .clear      (fifo_clear),
        .head_valid (head_valid),
        .head_data  (head_data),
        .level      (fifo_level)
    );

    // Fetch FSM: request issue, ack acceptance, flush redirection and discard.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        rom_req    = 1'b0;
        fifo_clear = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (started_q) begin
                    if (flush) begin
                        fifo_clear = 1'b1;
                        pc_d       = flush_pc;
                    end else if (room_idle) begin
                        rom_req = 1'b1;
                        state_d = WAIT;
                        accept  = rom_ack;
                    end
                end
            end
            WAIT: begin
                rom_req = 1'b1;
                if (flush) begin
                    fifo_clear = 1'b1;
                    if (rom_ack) begin
                        pc_d    = flush_pc;
                        state_d = IDLE;
                    end else begin
                        target_d = flush_pc;
                        state_d  = DROP;
                    end
                end else begin
                    accept = rom_ack;
                end
            end
            DROP: begin
                rom_req    = 1'b1;
                fifo_clear = flush;
                if (flush) begin
                    target_d = flush_pc;
                end
                if (rom_ack) begin
                    pc_d    = flush ? flush_pc : target_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            pc_d = pc_q + ADDR_W'(INST_BYTES);
            if (!bypass && !room_after) begin
                state_d = IDLE;
            end
        end
    end

    // Present the FIFO head, or the live ROM word when it bypasses the FIFO.
    always_comb begin
        if_pc   = '0;
        if_inst = '0;
        if (head_valid) begin
            {if_pc, if_inst} = head_data;
        end else if (bypass) begin
            if_pc   = pc_q;
            if_inst = rom_rdata;
        end
    end

    // State, PC and redirect target registers; started_q holds off the first
    // request until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            target_q  <= RESET_PC;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            started_q <= 1'b1;
        end
    end

endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Instruction prefetch stage sitting between the instruction ROM and the IF/ID pipeline register of the minimal SOPC. It owns the program counter, issues word fetches to the ROM over a req/ack handshake that tolerates wait states, and buffers returned `{pc, inst}` pairs in a small FIFO. It presents them to IF/ID through a valid/ready interface. A flush input redirects fetch on branches or jumps and discards any stale words already in flight.

## Interface
- `ADDR_W`, 32, PC/ROM address width.
- `DATA_W`, 32, instruction width.
- `DEPTH`, 4, FIFO entries; must be a power of two and ≥2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `rom_req`  out  1  fetch request.
- `rom_addr`  out  ADDR_W  fetch address; held stable while `rom_req` is high and no ack has arrived.
- `rom_ack`  in  1  data valid from the ROM; may arrive in the same cycle as `rom_req`.
- `rom_rdata`  in  DATA_W  instruction word; sampled when `rom_ack` is high.
- `flush`  in  1  redirect request.
- `flush_pc`  in  ADDR_W  redirect target.
- `if_valid`  out  1  `if_pc`/`if_inst` hold a valid entry.
- `if_ready`  in  1  IF/ID accepts the entry; a pop occurs when `if_valid` and `if_ready` are both high.
- `if_pc`  out  ADDR_W  address of the presented instruction.
- `if_inst`  out  DATA_W  presented instruction.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Internal state:
  - `pc`: next fetch address.
  - FIFO of `{pc, inst}` entries.
  - FSM with states IDLE, WAIT and DROP.
- IDLE:
  - If `fifo_level` plus the number of pops this cycle is less than DEPTH, assert `rom_req` with `rom_addr = pc` and go to WAIT.
  - If `rom_ack` arrives in that same cycle, the fetch is treated as completed in WAIT (see below).
- WAIT:
  - Keep `rom_req` high.
  - On `rom_ack`: push `{rom_addr, rom_rdata}` and set `pc ← pc + 4` (wraps modulo 2^ADDR_W).
  - If FIFO space remains, issue the next request back-to-back; otherwise return to IDLE.
- Flush, when the FSM is in IDLE or when `rom_ack` is high in WAIT:
  - Clear the FIFO and set `pc ← flush_pc`.
  - Any ack arriving that cycle is discarded.
  - Go to IDLE.
- Flush in WAIT with no ack:
  - Clear the FIFO, latch `flush_pc`, and go to DROP.
  - DROP keeps `rom_req` high at the old address. The next ack is discarded, then the FSM goes to IDLE with `pc = flush_pc`.
- A further flush while in DROP overwrites the latched target.
- Flush has priority over both push and pop; no pop is counted in a flush cycle.
- Push while full cannot occur by construction; the bench checks this with an assertion.
- The low two bits of `flush_pc` are used as-is; no alignment check is made.

## Timing
- Reset values:
  - `rom_req` = 0, `rom_addr` = `RESET_PC`.
  - `if_valid` = 0, `if_pc` = 0, `if_inst` = 0, `fifo_level` = 0.
  - `pc` = `RESET_PC`, FSM in IDLE.
- First `rom_req` is asserted in the first cycle after `rst` deasserts.
- Latency:
  - Ack to `if_valid`: 1 cycle (registered FIFO output).
  - Flush to `if_valid` low: next cycle.
- Throughput: one instruction per cycle with a zero-wait ROM and `if_ready` held high.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous reset). An outstanding ROM access is abandoned without waiting for its ack.

## Configuration
- `IF_BYPASS_EN`:
  - Defined: when the FIFO is empty, `rom_ack` is high, `if_ready` is high and there is no flush, the ROM word drives `if_valid`, `if_pc` and `if_inst` combinationally in the same cycle and is not pushed. This gives 0-cycle latency.
  - Undefined: every word passes through the FIFO, giving 1-cycle latency and no combinational path from the ROM to IF/ID.

## Structure
- Package `if_pkg` holds:
  - FSM state enum `if_state_t` (IDLE, WAIT, DROP).
  - `INST_BYTES = 4`.
  - `fetch_entry_t` struct `{pc, inst}`.
- Sub-module `if_fifo`: synchronous FIFO with DEPTH entries, push/pop/clear ports, registered head output and level count.

## Test plan
- Release reset with a zero-wait ROM and `if_ready` = 1 → `rom_addr` sequence 0, 4, 8, …; `if_valid` high from cycle 2 with `if_pc` = 0, 4, 8 on consecutive cycles.
- Hold `if_ready` = 0 → exactly 4 words are buffered, then `rom_req` drops; set `if_ready` = 1 → entries pc 0, 4, 8, C drain in order.
- ROM with 3 wait states → `rom_addr` stays stable until ack; one instruction every 4 cycles.
- Flush to 0x100 while WAIT is pending on 0x10 → the 0x10 word is never presented; the next `if_pc` is 0x100.
- Flush in the same cycle as an ack and a pop → FIFO empty next cycle, `fifo_level` = 0, next fetch address is `flush_pc`.
- Assert `rst` (drive to 0) mid-WAIT → `rom_req` = 0 and `if_valid` = 0 immediately; after release, fetch restarts at `RESET_PC`.
